// File: rtl/key_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// key_sweep_ctrl
//   Steps through an inclusive range of candidate keys on the key-checker chip.
//   For each key it holds chip_key stable, produces one full chip_clk pulse,
//   waits for the chip output to settle, samples chip_data and compares it
//   against a masked target. The sweep stops on the first hit, at the end of
//   the range, or on abort.
//
// Ports
//   clk, rst_n         system clock, asynchronous active-low reset
//   start              begin a sweep (sampled only while idle)
//   abort              stop the running sweep at the next edge
//   key_lo, key_hi     inclusive key range, captured on start
//   target, mask       expected chip_data and compare mask (1 = checked)
//   chip_data          checker chip output
//   chip_key, chip_clk registered drive to the checker chip
//   busy               sweep in progress
//   done               one-cycle pulse at the end of every sweep
//   found, found_key   last sweep hit and the matching key
//   aborted            last sweep was ended by abort
//   tries              number of keys checked in the last sweep
// -----------------------------------------------------------------------------
module key_sweep_ctrl #(
  parameter int KEY_W      = 32,
  parameter int DATA_W     = 32,
  parameter int SETUP_CYC  = 2,
  parameter int HIGH_CYC   = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [KEY_W-1:0]  key_lo,
  input  logic [KEY_W-1:0]  key_hi,
  input  logic [DATA_W-1:0] target,
  input  logic [DATA_W-1:0] mask,
  input  logic [DATA_W-1:0] chip_data,
  output logic [KEY_W-1:0]  chip_key,
  output logic              chip_clk,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic              aborted,
  output logic [KEY_W-1:0]  found_key,
  output logic [KEY_W:0]    tries
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_SETTLE,
    S_CHECK,
    S_FIN
  } state_t;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST   = CNT_W'(HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [KEY_W-1:0]   key_hi_q, key_hi_d;
  logic [DATA_W-1:0]  target_q, target_d;
  logic [DATA_W-1:0]  mask_q, mask_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [KEY_W-1:0]   chip_key_q, chip_key_d;
  logic               chip_clk_q, chip_clk_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               found_q, found_d;
  logic               aborted_q, aborted_d;
  logic [KEY_W-1:0]   found_key_q, found_key_d;
  logic [KEY_W:0]     tries_q, tries_d;

  logic               active;
  logic               abort_act;
  logic               hit;
  logic               last_key;

  // abort is only honoured while a key is being processed; IDLE and FIN ignore it.
  assign active    = (state_q == S_SETUP) || (state_q == S_HIGH) ||
                     (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign abort_act = abort && active;
  assign hit       = ((data_q ^ target_q) & mask_q) == '0;
  // End of range is tested before incrementing, so key_hi = all-ones never wraps.
  assign last_key  = (chip_key_q == key_hi_q);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in a combinational block gets a default at the
  // top so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = (key_lo > key_hi) ? S_FIN : S_SETUP;
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_q == HIGH_LAST) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: state_d = (hit || last_key) ? S_FIN : S_SETUP;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort overrides everything, including a same-cycle hit in CHECK.
    if (abort_act) begin
      state_d = S_FIN;
      cnt_d   = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    key_hi_d    = key_hi_q;
    target_d    = target_q;
    mask_d      = mask_q;
    data_d      = data_q;
    chip_key_d  = chip_key_q;
    found_d     = found_q;
    aborted_d   = aborted_q;
    found_key_d = found_key_q;
    tries_d     = tries_q;

    if (state_q == S_IDLE && start) begin
      key_hi_d   = key_hi;
      target_d   = target;
      mask_d     = mask;
      chip_key_d = key_lo;
      found_d    = 1'b0;
      aborted_d  = 1'b0;
      tries_d    = '0;
    end

    // chip_data is captured on the final settle edge, just as CHECK is entered.
    if (state_q == S_SETTLE && state_d == S_CHECK) data_d = chip_data;

    if (state_q == S_CHECK && !abort_act) begin
      tries_d = tries_q + 1'b1;
      if (hit) begin
        found_d     = 1'b1;
        found_key_d = chip_key_q;
      end else if (!last_key) begin
        chip_key_d = chip_key_q + 1'b1;
      end
    end

    if (abort_act) aborted_d = 1'b1;

    // chip_clk follows the next state so it is a clean registered level and
    // drops on the very edge that takes an abort.
    chip_clk_d = (state_d == S_HIGH);
    busy_d     = (state_d != S_IDLE);
    // done is registered off FIN, so it appears in the first idle cycle with busy low.
    done_d     = (state_q == S_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_hi_q    <= '0;
      target_q    <= '0;
      mask_q      <= '0;
      data_q      <= '0;
      chip_key_q  <= '0;
      chip_clk_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      aborted_q   <= 1'b0;
      found_key_q <= '0;
      tries_q     <= '0;
    end else begin
      key_hi_q    <= key_hi_d;
      target_q    <= target_d;
      mask_q      <= mask_d;
      data_q      <= data_d;
      chip_key_q  <= chip_key_d;
      chip_clk_q  <= chip_clk_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      found_q     <= found_d;
      aborted_q   <= aborted_d;
      found_key_q <= found_key_d;
      tries_q     <= tries_d;
    end
  end

  assign chip_key  = chip_key_q;
  assign chip_clk  = chip_clk_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign aborted   = aborted_q;
  assign found_key = found_key_q;
  assign tries     = tries_q;

endmodule

// File: tb/tb_key_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_sweep_ctrl
//   Directed and randomized sweeps of key_sweep_ctrl against a checker-chip
//   stand-in. Expected results come from a range-walking reference model that
//   works from the sweep rules (first masked match, 7 cycles per key, abort
//   timing), not from the controller's state machine.
// -----------------------------------------------------------------------------
module tb_key_sweep_ctrl;

  localparam logic [31:0] MAGIC    = 32'h9DA79FF1;
  localparam logic [31:0] HIT_DATA = 32'hC0FFEE00;
  localparam int          CYC_KEY  = 7;
  localparam int          LIMIT    = 2000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] key_lo;
  logic [31:0] key_hi;
  logic [31:0] target;
  logic [31:0] mask;
  logic [31:0] chip_data;
  logic [31:0] chip_key;
  logic        chip_clk;
  logic        busy;
  logic        done;
  logic        found;
  logic        aborted;
  logic [31:0] found_key;
  logic [32:0] tries;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;

  key_sweep_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .key_lo    (key_lo),
    .key_hi    (key_hi),
    .target    (target),
    .mask      (mask),
    .chip_data (chip_data),
    .chip_key  (chip_key),
    .chip_clk  (chip_clk),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .aborted   (aborted),
    .found_key (found_key),
    .tries     (tries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] chip_model(input logic [31:0] k);
    return (k == MAGIC) ? HIT_DATA : 32'h0;
  endfunction

  assign chip_data = chip_model(chip_key);

  always @(posedge chip_clk) pulses <= pulses + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the range, stop at the first masked match; each key costs
  // 7 cycles and done shows one cycle after the last key's check.
  task automatic model(input logic [31:0] lo, input logic [31:0] hi,
                       input logic [31:0] tgt, input logic [31:0] msk,
                       input int abort_at,
                       output bit fnd, output logic [31:0] fkey,
                       output longint n_tries, output int done_at,
                       output int n_pulses, output logic [31:0] end_key,
                       output bit abrt);
    longint n = 0;
    fnd = 0; fkey = '0; abrt = 0;
    if (lo <= hi) begin
      for (longint unsigned k = lo; k <= hi; k++) begin
        n++;
        if (((chip_model(k[31:0]) ^ tgt) & msk) == 32'h0) begin
          fnd  = 1;
          fkey = k[31:0];
          break;
        end
      end
    end
    if (abort_at > 0 && longint'(abort_at) <= CYC_KEY * n) begin
      // A key's check lands at edge 7(k+1); an abort on that same edge wins.
      abrt     = 1;
      fnd      = 0;
      n_tries  = longint'((abort_at - 1) / CYC_KEY);
      done_at  = abort_at + 1;
      n_pulses = 0;
      for (int k = 0; k < n; k++) if (CYC_KEY * k + 2 < abort_at) n_pulses++;
      end_key  = lo + 32'(n_tries);
    end else begin
      n_tries  = n;
      done_at  = int'(CYC_KEY * n + 1);
      n_pulses = int'(n);
      end_key  = (n == 0) ? lo : lo + 32'(n - 1);
    end
  endtask

  task automatic sweep(input string name, input logic [31:0] lo, input logic [31:0] hi,
                       input logic [31:0] tgt, input logic [31:0] msk,
                       input int abort_at, input bit abort_with_start);
    bit          e_fnd, e_abrt, got;
    logic [31:0] e_fkey, e_end;
    longint      e_tries;
    int          e_done, e_pulses, p0, k;
    model(lo, hi, tgt, msk, abort_at, e_fnd, e_fkey, e_tries, e_done, e_pulses, e_end, e_abrt);
    p0     = pulses;
    key_lo = lo; key_hi = hi; target = tgt; mask = msk;
    start  = 1'b1;
    abort  = abort_with_start;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check({name, "_busy_after_start"}, busy, 1);
    k   = 0;
    got = 0;
    while (!got && k < LIMIT) begin
      if (abort_at > 0 && k == abort_at - 1) abort = 1'b1;
      @(posedge clk); k++; #1;
      abort = 1'b0;
      if (done) got = 1;
    end
    check({name, "_done_seen"}, got, 1);
    check({name, "_done_cycle"}, k, e_done);
    check({name, "_busy_at_done"}, busy, 0);
    check({name, "_found"}, found, e_fnd);
    if (e_fnd) check({name, "_found_key"}, found_key, e_fkey);
    check({name, "_tries"}, tries, e_tries);
    check({name, "_aborted"}, aborted, e_abrt);
    check({name, "_chip_key"}, chip_key, e_end);
    check({name, "_chip_clk"}, chip_clk, 0);
    check({name, "_pulses"}, pulses - p0, e_pulses);
    @(posedge clk); #1;
    check({name, "_done_one_cycle"}, done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    key_lo = '0; key_hi = '0; target = '0; mask = '0;
    #1;
    check("reset_chip_key", chip_key, 0);
    check("reset_chip_clk", chip_clk, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_found", found, 0);
    check("reset_aborted", aborted, 0);
    check("reset_found_key", found_key, 0);
    check("reset_tries", tries, 0);
    #20;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // abort while idle does nothing
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_done", done, 0);
    check("idle_abort_aborted", aborted, 0);

    sweep("t1", 32'h9DA79FF0, 32'h9DA79FF1, HIT_DATA, 32'hFFFFFFFF, 0, 0);
    sweep("t2", 32'h0, 32'h3, HIT_DATA, 32'hFFFFFFFF, 0, 0);
    sweep("t3", 32'h5, 32'h4, HIT_DATA, 32'hFFFFFFFF, 0, 0);
    sweep("t4a", 32'hFFFFFFFE, 32'hFFFFFFFF, HIT_DATA, 32'h0, 0, 0);
    sweep("t4b", 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0);
    sweep("t5", 32'h0, 32'h0000FFFF, HIT_DATA, 32'hFFFFFFFF, 20, 0);
    // abort on the same edge as the hitting check: abort wins
    sweep("abort_vs_hit", 32'h9DA79FF0, 32'h9DA79FF1, HIT_DATA, 32'hFFFFFFFF, 14, 0);
    // start and abort together: the sweep runs normally
    sweep("start_with_abort", 32'h9DA79FF0, 32'h9DA79FF1, HIT_DATA, 32'hFFFFFFFF, 0, 1);

    // t6: reset during HIGH of a t2 sweep
    key_lo = 32'h0; key_hi = 32'h3; target = HIT_DATA; mask = 32'hFFFFFFFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("t6_in_high", chip_clk, 1);
    rst_n = 1'b0;
    #1;
    check("t6_chip_key", chip_key, 0);
    check("t6_chip_clk", chip_clk, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_found", found, 0);
    check("t6_aborted", aborted, 0);
    check("t6_found_key", found_key, 0);
    check("t6_tries", tries, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    sweep("t6_restart", 32'h9DA79FF0, 32'h9DA79FF1, HIT_DATA, 32'hFFFFFFFF, 0, 0);

    // randomized sweeps around the matching key
    for (int i = 0; i < 12; i++) begin
      logic [31:0] lo, hi, tgt, msk;
      int          ab;
      lo = MAGIC - 32'($urandom_range(0, 3));
      hi = lo + 32'($urandom_range(0, 4)) - 32'd1;
      case ($urandom_range(0, 2))
        0:       msk = 32'hFFFFFFFF;
        1:       msk = 32'h0;
        default: msk = $urandom;
      endcase
      case ($urandom_range(0, 2))
        0:       tgt = HIT_DATA;
        1:       tgt = 32'h0;
        default: tgt = $urandom;
      endcase
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
      sweep($sformatf("rand%0d", i), lo, hi, tgt, msk, ab, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
